// File: rtl/prog_fetch_pkg.sv
// prog_fetch_pkg: shared state encoding, default geometry and sizing helpers for the fetch unit.
package prog_fetch_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PROG = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } state_e;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_INST_BYTES = 4;
   localparam int DEF_DEPTH = 64;
   localparam logic [8*DEF_INST_BYTES-1:0] DEF_HALT_WORD = '1;
   function automatic int ib_log2(input int ib);
      return $clog2(ib);
   endfunction
   function automatic int mem_bytes(input int depth, input int ib);
      return depth * ib;
   endfunction
   localparam int DEF_IB_LOG2 = ib_log2(DEF_INST_BYTES);
   localparam int DEF_MEM_BYTES = mem_bytes(DEF_DEPTH, DEF_INST_BYTES);
endpackage

// File: rtl/inst_ram_bytewise.sv
// inst_ram_bytewise: byte-addressed instruction store with one byte write port,
// a registered little-endian word fetch port and a registered byte read-back port.
module inst_ram_bytewise
   import prog_fetch_pkg::*;
#(
   parameter int INST_BYTES = DEF_INST_BYTES,
   parameter int DEPTH = DEF_DEPTH,
   localparam int MEM_BYTES = mem_bytes(DEPTH, INST_BYTES),
   localparam int IW = $clog2(MEM_BYTES)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [IW-1:0]           waddr_i,
   input  logic [7:0]              wdata_i,
   input  logic                    fetch_en_i,
   input  logic [IW-1:0]           fetch_addr_i,
   output logic [8*INST_BYTES-1:0] fetch_data_o,
   input  logic                    rd_ok_i,
   input  logic [IW-1:0]           rd_addr_i,
   output logic [7:0]              rd_data_o
);
   logic [7:0] mem_q [MEM_BYTES];
   logic [8*INST_BYTES-1:0] word, fetch_q;
   logic [7:0] rd_q;

   always_comb begin
      word = '0;
      for (int b = 0; b < INST_BYTES; b++)
         word[8*b +: 8] = mem_q[fetch_addr_i + IW'(b)];
   end

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // reads sample the array before this edge's write lands, so a colliding write returns old data
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_q <= '0;
         rd_q <= '0;
      end else begin
         if (fetch_en_i) fetch_q <= word;
         rd_q <= rd_ok_i ? mem_q[rd_addr_i] : 8'h00;
      end
   end

   assign fetch_data_o = fetch_q;
   assign rd_data_o = rd_q;
endmodule

// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit: program counter and IDLE/PROG/RUN/HALT controller in front of a
// byte-writable instruction store; supports wrap, jump, stall, single-step and HALT detection.
module prog_fetch_unit
   import prog_fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int INST_BYTES = DEF_INST_BYTES,
   parameter int DEPTH = DEF_DEPTH,
   parameter logic [8*INST_BYTES-1:0] HALT_WORD = {(8*INST_BYTES){1'b1}}
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_prog_en,
   input  logic                    i_run,
   input  logic                    i_step,
   input  logic                    i_stall,
   input  logic                    i_jump_valid,
   input  logic [ADDR_W-1:0]       i_jump_target,
   input  logic                    i_wr_valid,
   input  logic [ADDR_W-1:0]       i_wr_addr,
   input  logic [7:0]              i_wr_data,
   output logic                    o_wr_ready,
   input  logic [ADDR_W-1:0]       i_rd_addr,
   output logic [7:0]              o_rd_data,
   output logic [ADDR_W-1:0]       o_pc,
   output logic [8*INST_BYTES-1:0] o_inst,
   output logic [ADDR_W-1:0]       o_inst_pc,
   output logic                    o_inst_valid,
   output logic [1:0]              o_state
);
   localparam int IB_LOG2 = ib_log2(INST_BYTES);
   localparam int MEM_BYTES = mem_bytes(DEPTH, INST_BYTES);
   localparam int IW = $clog2(MEM_BYTES);
   localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(MEM_BYTES);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN = {ADDR_W{1'b1}} << IB_LOG2;

   state_e state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, inst_pc_q, pc_inc, jump_al, jump_pc;
   logic [ADDR_W:0] pc_sum;
   logic valid_q, fetch, halt_hit, we;

   assign pc_sum = {1'b0, pc_q} + {1'b0, STEP};
   assign pc_inc = pc_sum >= LIM ? '0 : pc_sum[ADDR_W-1:0];
   assign jump_al = i_jump_target & ALIGN;
   assign jump_pc = {1'b0, jump_al} >= LIM ? '0 : jump_al;
   assign halt_hit = valid_q && o_inst == HALT_WORD;
   assign we = i_wr_valid && state_q == ST_PROG && {1'b0, i_wr_addr} < LIM && !i_rst;

   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      fetch = 1'b0;
      if (i_prog_en) state_d = ST_PROG;
      else
         case (state_q)
            ST_PROG: begin
               state_d = ST_IDLE;
               pc_d = '0;
            end
            ST_IDLE: begin
               state_d = i_run ? ST_RUN : ST_IDLE;
               fetch = !i_run && i_step;
               pc_d = fetch ? pc_inc : pc_q;
            end
            ST_RUN: begin
               // HALT outranks jump/stall; a jump always suppresses the fetch
               state_d = !i_run ? ST_IDLE : halt_hit ? ST_HALT : ST_RUN;
               fetch = i_run && !halt_hit && !i_jump_valid && !i_stall;
               pc_d = !i_run ? '0 : halt_hit ? pc_q : i_jump_valid ? jump_pc : fetch ? pc_inc : pc_q;
            end
            ST_HALT: begin
               state_d = i_run ? ST_HALT : ST_IDLE;
               pc_d = i_run ? pc_q : '0;
            end
         endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         pc_q <= '0;
         valid_q <= 1'b0;
         inst_pc_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         valid_q <= fetch;
         inst_pc_q <= fetch ? pc_q : inst_pc_q;
      end
   end

   inst_ram_bytewise #(
      .INST_BYTES(INST_BYTES),
      .DEPTH(DEPTH)
   ) u_ram (
      .clk(i_clk),
      .rst(i_rst),
      .we_i(we),
      .waddr_i(i_wr_addr[IW-1:0]),
      .wdata_i(i_wr_data),
      .fetch_en_i(fetch),
      .fetch_addr_i(pc_q[IW-1:0]),
      .fetch_data_o(o_inst),
      .rd_ok_i({1'b0, i_rd_addr} < LIM),
      .rd_addr_i(i_rd_addr[IW-1:0]),
      .rd_data_o(o_rd_data)
   );

   assign o_wr_ready = state_q == ST_PROG;
   assign o_pc = pc_q;
   assign o_inst_pc = inst_pc_q;
   assign o_inst_valid = valid_q;
   assign o_state = state_q;
endmodule

// File: tb/tb_prog_fetch_unit.sv
// tb_prog_fetch_unit: directed-vector bench for prog_fetch_unit with DEPTH=4 (16-byte store).
module tb_prog_fetch_unit;
   logic clk = 1'b0;
   logic rst, prog_en, run, step, stall, jump_valid, wr_valid;
   logic [7:0] jump_target, wr_addr, wr_data, rd_addr;
   logic wr_ready, inst_valid;
   logic [7:0] rd_data, pc, inst_pc;
   logic [31:0] inst;
   logic [1:0] state;
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_inst [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

   always #5 clk = ~clk;

   prog_fetch_unit #(.ADDR_W(8), .INST_BYTES(4), .DEPTH(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_prog_en(prog_en), .i_run(run), .i_step(step),
      .i_stall(stall), .i_jump_valid(jump_valid), .i_jump_target(jump_target),
      .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
      .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_pc(pc), .o_inst(inst), .o_inst_pc(inst_pc),
      .o_inst_valid(inst_valid), .o_state(state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_valid = 1'b0;
   endtask

   initial begin
      {prog_en, run, step, stall, jump_valid, wr_valid} = '0;
      {jump_target, wr_addr, wr_data, rd_addr} = '0;
      rst = 1'b1;
      tick();
      tick();
      check("rst_state", 32'(state), 0);
      check("rst_pc", 32'(pc), 0);
      check("rst_valid", 32'(inst_valid), 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", 32'(inst_pc), 0);
      check("rst_wr_ready", 32'(wr_ready), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      rst = 1'b0;
      prog_en = 1'b1;
      tick();
      check("prog_state", 32'(state), 1);
      check("prog_wr_ready", 32'(wr_ready), 1);
      for (int i = 0; i < 16; i++) wr(8'(i), 8'(i));
      wr(8'hFF, 8'hAA);
      check("oor_wr_ready", 32'(wr_ready), 1);
      rd_addr = 8'd3;
      wr(8'd3, 8'h33);
      check("rd_old_on_collide", 32'(rd_data), 32'h03);
      tick();
      check("rd_new_after_wr", 32'(rd_data), 32'h33);
      wr(8'd3, 8'h03);
      rd_addr = 8'd5;
      tick();
      check("rd_addr5", 32'(rd_data), 32'h05);
      rd_addr = 8'hFF;
      tick();
      check("rd_oor", 32'(rd_data), 0);
      prog_en = 1'b0;
      run = 1'b1;
      tick();
      check("prog_exit_state", 32'(state), 0);
      tick();
      check("run_state", 32'(state), 2);
      check("run_first_valid", 32'(inst_valid), 0);
      for (int i = 0; i < 7; i++) begin
         tick();
         check($sformatf("run%0d_valid", i), 32'(inst_valid), 1);
         check($sformatf("run%0d_pc", i), 32'(inst_pc), 32'((i % 4) * 4));
         check($sformatf("run%0d_inst", i), inst, exp_inst[i % 4]);
      end
      check("pc_after_run", 32'(pc), 12);
      jump_valid = 1'b1;
      jump_target = 8'h09;
      stall = 1'b1;
      tick();
      jump_valid = 1'b0;
      check("jump_valid", 32'(inst_valid), 0);
      check("jump_pc", 32'(pc), 8);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall%0d_valid", i), 32'(inst_valid), 0);
         check($sformatf("stall%0d_pc", i), 32'(pc), 8);
      end
      stall = 1'b0;
      tick();
      check("post_jump_valid", 32'(inst_valid), 1);
      check("post_jump_inst_pc", 32'(inst_pc), 8);
      check("post_jump_inst", inst, exp_inst[2]);
      jump_valid = 1'b1;
      jump_target = 8'hF0;
      tick();
      jump_valid = 1'b0;
      check("jump_oor_pc", 32'(pc), 0);
      run = 1'b0;
      tick();
      check("stop_state", 32'(state), 0);
      check("stop_pc", 32'(pc), 0);
      check("stop_valid", 32'(inst_valid), 0);
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         check($sformatf("step%0d_valid", i), 32'(inst_valid), 1);
         check($sformatf("step%0d_pc", i), 32'(inst_pc), 32'(i * 4));
         check($sformatf("step%0d_inst", i), inst, exp_inst[i]);
         tick();
         check($sformatf("step%0d_gap", i), 32'(inst_valid), 0);
      end
      check("step_state", 32'(state), 0);
      check("step_pc", 32'(pc), 12);
      prog_en = 1'b1;
      tick();
      for (int i = 8; i < 12; i++) wr(8'(i), 8'hFF);
      prog_en = 1'b0;
      tick();
      run = 1'b1;
      tick();
      tick();
      tick();
      tick();
      check("halt_fetch_valid", 32'(inst_valid), 1);
      check("halt_fetch_inst", inst, 32'hFFFFFFFF);
      check("halt_fetch_pc", 32'(inst_pc), 8);
      tick();
      check("halt_state", 32'(state), 3);
      check("halt_pc", 32'(pc), 12);
      check("halt_valid", 32'(inst_valid), 0);
      tick();
      check("halt_hold_state", 32'(state), 3);
      check("halt_hold_valid", 32'(inst_valid), 0);
      run = 1'b0;
      tick();
      check("halt_exit_state", 32'(state), 0);
      check("halt_exit_pc", 32'(pc), 0);
      run = 1'b1;
      tick();
      tick();
      check("pre_rst_valid", 32'(inst_valid), 1);
      rst = 1'b1;
      rd_addr = 8'd1;
      tick();
      check("midrst_state", 32'(state), 0);
      check("midrst_pc", 32'(pc), 0);
      check("midrst_valid", 32'(inst_valid), 0);
      check("midrst_inst", inst, 0);
      check("midrst_inst_pc", 32'(inst_pc), 0);
      check("midrst_rd", 32'(rd_data), 0);
      rst = 1'b0;
      run = 1'b0;
      tick();
      check("retained_rd1", 32'(rd_data), 32'h01);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
